lfsr_region_scheduler: RTL and testbench

Controller that sequences one `lfsr_param` message generator across a list of search regions for the DES key-search datapath. For each region it:
- computes the region seed (base + index·stride),
- loads the seed and polynomial into the LFSR and starts it,
- throttles it with pause when the downstream DES input is near full,
- detects region completion and restarts the LFSR on the next seed.

It reports progress and the total count of generated messages to the host wrapper.

---
 rtl/lfsr_region_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_lfsr_region_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_region_scheduler.sv
// Steps one lfsr_param generator through a list of seed regions (seed = base + k*stride), throttles it
// from downstream back-pressure and counts its valid words. Optional watchdog: define SCHED_TIMEOUT_EN.
module lfsr_region_scheduler #(
    parameter int N         = 64,
    parameter int IDX_W     = 16,
    parameter int CNT_W     = 48,
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [N-1:0]         base_seed,
    input  logic [N-1:0]         seed_stride,
    input  logic [IDX_W-1:0]     num_regions,
    input  logic [N-1:0]         polynomial,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 out_almost_full,
    output logic                 lfsr_start,
    output logic                 lfsr_pause,
    output logic                 lfsr_reset_counter,
    output logic [N-1:0]         lfsr_seed,
    output logic [N-1:0]         lfsr_poly,
    input  logic                 lfsr_valid,
    input  logic                 lfsr_done,
    output logic                 busy,
    output logic [IDX_W-1:0]     region_idx,
    output logic [CNT_W-1:0]     msg_count,
    output logic                 run_done,
    output logic                 aborted
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RELOAD, ABORT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     seed_reg, seed_next;
    logic [N-1:0]     stride_reg, stride_next;
    logic [N-1:0]     poly_reg, poly_next;
    logic [IDX_W-1:0] num_reg, num_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             run_done_reg, run_done_next;
    logic             aborted_reg, aborted_next;
    logic             timeout_hit;

`ifdef SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_reg, wd_next;

    // In RUN the pause output equals out_almost_full, so the watchdog reads the input directly.
    always_comb begin
        wd_next     = wd_reg;
        timeout_hit = 1'b0;
        if (state_reg == START) begin
            wd_next = '0;
        end else if (state_reg == RUN && !out_almost_full) begin
            wd_next     = wd_reg + TIMEOUT_W'(1);
            timeout_hit = (timeout_cycles != '0) && (wd_next >= timeout_cycles);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next         = state_reg;
        seed_next          = seed_reg;
        stride_next        = stride_reg;
        poly_next          = poly_reg;
        num_next           = num_reg;
        idx_next           = idx_reg;
        count_next         = count_reg;
        run_done_next      = run_done_reg;
        aborted_next       = aborted_reg;
        lfsr_start         = 1'b0;
        lfsr_pause         = 1'b0;
        lfsr_reset_counter = 1'b0;
        busy               = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_start) begin
                    seed_next     = base_seed;
                    stride_next   = seed_stride;
                    poly_next     = polynomial;
                    num_next      = num_regions;
                    idx_next      = '0;
                    count_next    = '0;
                    run_done_next = 1'b0;
                    aborted_next  = 1'b0;
                    state_next    = (num_regions == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = cmd_abort ? ABORT : START;
            end
            START: begin
                busy       = 1'b1;
                lfsr_start = 1'b1;
                state_next = cmd_abort ? ABORT : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                lfsr_pause = out_almost_full;
                if (lfsr_valid && count_reg != '1) begin
                    count_next = count_reg + CNT_W'(1);
                end
                // Abort (host or watchdog) takes priority over a simultaneous region completion.
                if (cmd_abort || timeout_hit) begin
                    state_next = ABORT;
                end else if (lfsr_done) begin
                    if (idx_reg == num_reg - IDX_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        seed_next  = seed_reg + stride_reg;
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = RELOAD;
                    end
                end
            end
            RELOAD: begin
                busy               = 1'b1;
                lfsr_reset_counter = 1'b1;
                state_next         = cmd_abort ? ABORT : LOAD;
            end
            ABORT: begin
                lfsr_reset_counter = 1'b1;
                aborted_next       = 1'b1;
                state_next         = IDLE;
            end
            DONE: begin
                run_done_next = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            seed_reg     <= '0;
            stride_reg   <= '0;
            poly_reg     <= '0;
            num_reg      <= '0;
            idx_reg      <= '0;
            count_reg    <= '0;
            run_done_reg <= 1'b0;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            seed_reg     <= seed_next;
            stride_reg   <= stride_next;
            poly_reg     <= poly_next;
            num_reg      <= num_next;
            idx_reg      <= idx_next;
            count_reg    <= count_next;
            run_done_reg <= run_done_next;
            aborted_reg  <= aborted_next;
        end
    end

    // The seed register already holds the next region's seed during RELOAD.
    assign lfsr_seed  = seed_reg;
    assign lfsr_poly  = poly_reg;
    assign region_idx = idx_reg;
    assign msg_count  = count_reg;
    assign run_done   = run_done_reg;
    assign aborted    = aborted_reg;

endmodule

// File: tb/tb_lfsr_region_scheduler.sv
// Self-checking bench for lfsr_region_scheduler with a behavioural LFSR stand-in that emits
// 256 words per region (none for an all-ones seed, endless for a zero polynomial).
module tb_lfsr_region_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [7:0]  base_seed = '0;
    logic [7:0]  seed_stride = '0;
    logic [15:0] num_regions = '0;
    logic [7:0]  polynomial = '0;
    logic [15:0] timeout_cycles = '0;
    logic        out_almost_full = 1'b0;
    logic        lfsr_start, lfsr_pause, lfsr_reset_counter;
    logic [7:0]  lfsr_seed, lfsr_poly;
    logic        lfsr_valid = 1'b0;
    logic        lfsr_done = 1'b0;
    logic        busy, run_done, aborted;
    logic [15:0] region_idx;
    logic [9:0]  msg_count;

    int total = 0;
    int bad = 0;

    lfsr_region_scheduler #(.N(8), .IDX_W(16), .CNT_W(10), .TIMEOUT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .base_seed(base_seed), .seed_stride(seed_stride), .num_regions(num_regions),
        .polynomial(polynomial), .timeout_cycles(timeout_cycles), .out_almost_full(out_almost_full),
        .lfsr_start(lfsr_start), .lfsr_pause(lfsr_pause), .lfsr_reset_counter(lfsr_reset_counter),
        .lfsr_seed(lfsr_seed), .lfsr_poly(lfsr_poly), .lfsr_valid(lfsr_valid), .lfsr_done(lfsr_done),
        .busy(busy), .region_idx(region_idx), .msg_count(msg_count), .run_done(run_done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // LFSR stand-in: reacts to pause one cycle late, drives its outputs on the falling edge.
    int stub_cnt = 0;
    int stub_len = 0;
    bit stub_run = 1'b0;
    bit pause_d = 1'b0;
    always @(negedge clk) begin
        lfsr_valid = 1'b0;
        lfsr_done  = 1'b0;
        if (rst || lfsr_reset_counter) begin
            stub_run = 1'b0;
        end else if (lfsr_start) begin
            stub_run = 1'b1;
            stub_cnt = 0;
            stub_len = (lfsr_seed == 8'hFF) ? 0 : ((lfsr_poly == 8'h00) ? -1 : 256);
        end else if (stub_run) begin
            if (stub_cnt == stub_len) begin
                lfsr_done = 1'b1;
                stub_run  = 1'b0;
            end else if (!pause_d) begin
                lfsr_valid = 1'b1;
                stub_cnt++;
            end
        end
        pause_d = lfsr_pause;
    end

    // Observation log, only ever appended to; tests work on deltas.
    int cyc = 0, n_start = 0, n_rc = 0, n_pause = 0, n_busy = 0, t_start = 0, t_rc = 0;
    logic [7:0]  seed_q[$];
    logic [7:0]  poly_q[$];
    logic [15:0] idx_q[$];
    always @(negedge clk) begin
        cyc++;
        if (lfsr_start === 1'b1) begin
            n_start++;
            t_start = cyc;
            seed_q.push_back(lfsr_seed);
            poly_q.push_back(lfsr_poly);
            idx_q.push_back(region_idx);
        end
        if (lfsr_reset_counter === 1'b1) begin
            n_rc++;
            t_rc = cyc;
        end
        if (lfsr_pause === 1'b1) n_pause++;
        if (busy === 1'b1) n_busy++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] b, input logic [7:0] s, input int n, input logic [7:0] p);
        base_seed   = b;
        seed_stride = s;
        num_regions = 16'(n);
        polynomial  = p;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, run_done, aborted, lfsr_start, lfsr_pause, lfsr_reset_counter} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, run_done, aborted, lfsr_start, lfsr_pause, lfsr_reset_counter});
        end
        total++;
        if ({lfsr_seed, lfsr_poly, region_idx, msg_count} !== 42'b0) begin
            bad++;
            $display("FAIL reset_values: seed=%h poly=%h idx=%0d count=%0d want all 0",
                     lfsr_seed, lfsr_poly, region_idx, msg_count);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // mode 0: plain, 1: almost-full held for 20 cycles in region 0, 2: cmd_start while busy
    task automatic run_and_check(input string name, input logic [7:0] base, input logic [7:0] stride,
                                 input int n, input logic [7:0] poly, input int mode);
        int s0 = seed_q.size();
        int st0 = n_start;
        int p0 = n_pause;
        int waited = 0;
        int msgs = 0;
        int exp_cnt;
        logic [7:0] es;
        load_cfg(base, stride, n, poly);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        while (run_done !== 1'b1 && waited < n * 300 + 50) begin
            if (mode == 1) out_almost_full = (waited >= 60 && waited < 80);
            if (mode == 2) begin
                cmd_start = (waited == 100);
                if (waited == 100) load_cfg(~base, stride + 8'h01, 1, 8'h00);
            end
            tick();
            waited++;
        end
        out_almost_full = 1'b0;
        cmd_start = 1'b0;
        total++;
        if (run_done !== 1'b1) begin
            bad++;
            $display("FAIL %s run_done: got %b want 1 within %0d cycles", name, run_done, waited);
        end
        total++;
        if (n_start - st0 != n) begin
            bad++;
            $display("FAIL %s start_pulses: got %0d want %0d", name, n_start - st0, n);
        end
        for (int i = 0; i < n; i++) begin
            es = 8'((int'(base) + i * int'(stride)) % 256);
            msgs += (es == 8'hFF) ? 0 : 256;
            total++;
            if (s0 + i >= seed_q.size()) begin
                bad++;
                $display("FAIL %s region%0d: no start pulse, want seed %h", name, i, es);
            end else if (seed_q[s0+i] !== es || idx_q[s0+i] !== 16'(i) || poly_q[s0+i] !== poly) begin
                bad++;
                $display("FAIL %s region%0d: got seed=%h idx=%0d poly=%h want seed=%h idx=%0d poly=%h",
                         name, i, seed_q[s0+i], idx_q[s0+i], poly_q[s0+i], es, i, poly);
            end
        end
        exp_cnt = (msgs > 1023) ? 1023 : msgs;
        total++;
        if (msg_count !== 10'(exp_cnt)) begin
            bad++;
            $display("FAIL %s msg_count: got %0d want %0d", name, msg_count, exp_cnt);
        end
        total++;
        if (busy !== 1'b0 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL %s end_flags: got busy=%b aborted=%b want 0 0", name, busy, aborted);
        end
        total++;
        if (n_pause - p0 != ((mode == 1) ? 20 : 0)) begin
            bad++;
            $display("FAIL %s pause_cycles: got %0d want %0d", name, n_pause - p0, (mode == 1) ? 20 : 0);
        end
        $display("run %s base=%h stride=%h n=%0d poly=%h mode=%0d msg_count=%0d", name, base, stride, n, poly,
                 mode, msg_count);
    endtask

    task automatic test_zero_regions();
        int st0 = n_start;
        int b0 = n_busy;
        load_cfg(8'h42, 8'h10, 0, 8'hB8);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        total++;
        if (run_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_regions_cycle1: got run_done=%b busy=%b want 0 0", run_done, busy);
        end
        tick();
        total++;
        if (run_done !== 1'b1) begin
            bad++;
            $display("FAIL zero_regions_done: got %b want 1 two cycles after start", run_done);
        end
        total++;
        if (n_start != st0 || n_busy != b0) begin
            bad++;
            $display("FAIL zero_regions_activity: got starts=%0d busy_cycles=%0d want 0 0",
                     n_start - st0, n_busy - b0);
        end
        $display("zero_regions run_done=%b", run_done);
    endtask

    task automatic test_abort();
        int st0 = n_start;
        int rc0, p0;
        int w = 0;
        load_cfg(8'h01, 8'h10, 3, 8'hB8);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        while (n_start - st0 < 2 && w < 1000) begin
            tick();
            w++;
        end
        total++;
        if (n_start - st0 != 2) begin
            bad++;
            $display("FAIL abort_reach_region1: got %0d starts want 2", n_start - st0);
        end
        repeat (20) tick();
        total++;
        if (region_idx !== 16'd1) begin
            bad++;
            $display("FAIL abort_region_idx: got %0d want 1", region_idx);
        end
        rc0 = n_rc;
        p0 = n_pause;
        cmd_abort = 1'b1;
        out_almost_full = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
        tick();
        out_almost_full = 1'b0;
        total++;
        if (n_rc - rc0 != 1) begin
            bad++;
            $display("FAIL abort_reset_counter: got %0d pulses want 1", n_rc - rc0);
        end
        total++;
        if (n_pause - p0 != 1) begin
            bad++;
            $display("FAIL abort_pause: got %0d pause cycles want 1 (last RUN cycle only)", n_pause - p0);
        end
        total++;
        if (aborted !== 1'b1 || busy !== 1'b0 || run_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_flags: got aborted=%b busy=%b run_done=%b want 1 0 0", aborted, busy, run_done);
        end
        $display("abort aborted=%b busy=%b", aborted, busy);
        run_and_check("restart", 8'h01, 8'h10, 3, 8'hB8, 0);
    endtask

    task automatic test_abort_vs_done();
        load_cfg(8'hFF, 8'h10, 2, 8'hB8);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
        total++;
        if (aborted !== 1'b1 || region_idx !== 16'd0 || busy !== 1'b0 || run_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_vs_done: got aborted=%b idx=%0d busy=%b run_done=%b want 1 0 0 0",
                     aborted, region_idx, busy, run_done);
        end
        $display("abort_vs_done aborted=%b idx=%0d", aborted, region_idx);
    endtask

    task automatic test_start_abort_idle();
        load_cfg(8'h07, 8'h01, 1, 8'hB8);
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        total++;
        if (busy !== 1'b1 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: got busy=%b aborted=%b want 1 0", busy, aborted);
        end
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
        total++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_load: got aborted=%b busy=%b want 1 0", aborted, busy);
        end
        $display("start_abort_idle aborted=%b", aborted);
    endtask

    task automatic test_reset_mid_run();
        load_cfg(8'h33, 8'h05, 2, 8'hB8);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || msg_count !== 10'd0 || lfsr_seed !== 8'h00 || lfsr_poly !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_run: got busy=%b count=%0d seed=%h poly=%h want 0 0 00 00",
                     busy, msg_count, lfsr_seed, lfsr_poly);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("reset_mid_run busy=%b", busy);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_and_check("random", 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)),
                          8'($urandom_range(1, 255)), ($urandom_range(0, 1) == 0) ? 0 : 2);
        end
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int rc0 = n_rc;
        int w = 0;
        timeout_cycles = 16'd100;
        load_cfg(8'h01, 8'h10, 2, 8'h00);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        while (n_rc == rc0 && w < 500) begin
            tick();
            w++;
        end
        tick();
        total++;
        if (aborted !== 1'b1 || busy !== 1'b0 || run_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flags: got aborted=%b busy=%b run_done=%b want 1 0 0", aborted, busy, run_done);
        end
        total++;
        if (t_rc - t_start - 1 != 100) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d RUN cycles want 100", t_rc - t_start - 1);
        end
        timeout_cycles = 16'd0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (10000) tick();
        total++;
        if (aborted !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_disabled: got aborted=%b busy=%b want 0 1", aborted, busy);
        end
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
        $display("timeout done aborted=%b", aborted);
    endtask
`else
    task automatic test_timeout();
        timeout_cycles = 16'd5;
        run_and_check("timeout_ignored", 8'h02, 8'h21, 2, 8'hB8, 0);
        timeout_cycles = 16'd0;
    endtask
`endif

    initial begin
        test_reset();
        run_and_check("plan1", 8'h01, 8'h10, 3, 8'hB8, 0);
        test_zero_regions();
        run_and_check("almost_full", 8'h01, 8'h10, 3, 8'hB8, 1);
        test_abort();
        run_and_check("wrap", 8'hF8, 8'h10, 2, 8'hB8, 0);
        run_and_check("lockup", 8'hEF, 8'h10, 3, 8'h1D, 0);
        run_and_check("saturate", 8'h01, 8'h01, 5, 8'hB8, 0);
        test_abort_vs_done();
        test_start_abort_idle();
        run_and_check("back_to_back", 8'h10, 8'h03, 2, 8'hB8, 2);
        test_reset_mid_run();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
